// File: rtl/mac_acc.sv
// mac_acc: grouped, multi-beat multiply-accumulate engine.
// Each beat carries NUM_LANES data/weight pairs split into up to MAX_GROUPS
// contiguous lane groups. Per-group dot products accumulate across beats and
// the final sum is presented on a valid/ready output.
// Pipeline: P1 lane products -> P2 group sums -> P3 accumulator / output.

// Per-lane multiplier: operands are sign- or zero-extended to the product
// width first, so the truncated product is exact in both modes.
module mac_acc_lane #(
    parameter int DATA_WIDTH = 8,
    parameter int PROD_WIDTH = 17
) (
    input  logic                  i_sgn,
    input  logic [DATA_WIDTH-1:0] i_d,
    input  logic [DATA_WIDTH-1:0] i_w,
    output logic [PROD_WIDTH-1:0] o_prod
);
    logic [PROD_WIDTH-1:0] w_d;
    logic [PROD_WIDTH-1:0] w_w;

    // extend both operands, then multiply modulo 2^PROD_WIDTH
    always_comb begin
        w_d    = i_sgn ? PROD_WIDTH'($signed(i_d)) : PROD_WIDTH'(i_d);
        w_w    = i_sgn ? PROD_WIDTH'($signed(i_w)) : PROD_WIDTH'(i_w);
        o_prod = w_d * w_w;
    end
endmodule

module mac_acc #(
    parameter int NUM_LANES  = 64,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_GROUPS = 8,
    parameter int LANE_BITS  = $clog2(NUM_LANES+1),
    parameter int ACC_WIDTH  = 32
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [$clog2(MAX_GROUPS+1)-1:0] num_groups,
    input  logic [MAX_GROUPS*LANE_BITS-1:0] group_lanes,
    input  logic                            is_signed,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic                            in_last,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] data,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] weight,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MAX_GROUPS*ACC_WIDTH-1:0] acc_out,
    output logic [MAX_GROUPS-1:0]           ovf_out,
    output logic                            cfg_err
);
    localparam int PW = 2*DATA_WIDTH + 1;             // product width
    localparam int GW = PW + $clog2(NUM_LANES);       // group-sum width
    localparam int GB = $clog2(MAX_GROUPS+1);         // group-count width
    localparam int SW = LANE_BITS + $clog2(MAX_GROUPS) + 1; // lane-index sums

    // control state
    logic                                 r_first;        // next accepted beat starts an accumulation
    logic                                 r_pending_last; // last beat in flight, inputs blocked
    logic                                 r_out_valid;
    logic [2:1]                           r_vld_pipe;     // P1/P2 stage valids

    // configuration captured on the first beat
    logic [GB-1:0]                        r_cfg_ng;
    logic [MAX_GROUPS-1:0][LANE_BITS-1:0] r_cfg_gl;
    logic                                 r_cfg_sgn;

    // pipeline registers
    logic [NUM_LANES-1:0][PW-1:0]         r_p1_prod;
    logic                                 r_p1_first, r_p1_last;
    logic [MAX_GROUPS-1:0][GW-1:0]        r_p2_sum;
    logic                                 r_p2_first, r_p2_last;
    logic [MAX_GROUPS-1:0][ACC_WIDTH-1:0] r_acc;
    logic [MAX_GROUPS-1:0]                r_ovf;
    logic [MAX_GROUPS-1:0][ACC_WIDTH-1:0] r_acc_out;
    logic [MAX_GROUPS-1:0]                r_ovf_out;
    logic                                 r_cfg_err;

    // combinational
    logic                                 w_accept, w_sgn, w_load, w_p2_hold, w_p3_fire;
    logic [NUM_LANES-1:0][PW-1:0]         w_prod;
    logic [MAX_GROUPS-1:0][SW-1:0]        w_start, w_end;
    logic [MAX_GROUPS-1:0]                w_act;
    logic [SW-1:0]                        w_run, w_tot;
    logic [MAX_GROUPS-1:0][GW-1:0]        w_gsum;
    logic [MAX_GROUPS-1:0][ACC_WIDTH-1:0] w_acc_nxt;
    logic [MAX_GROUPS-1:0]                w_ovf_nxt;
    logic [ACC_WIDTH-1:0]                 w_base, w_ext;
    logic [ACC_WIDTH:0]                   w_sum;
    logic                                 w_sov;

    assign in_ready  = !r_pending_last;
    assign w_accept  = in_valid && in_ready;
    // the first beat's products must use its own mode, not the stale one
    assign w_sgn     = r_first ? is_signed : r_cfg_sgn;
    // a last beat in P2 can only retire when the output register is free
    assign w_load    = r_vld_pipe[2] && r_p2_last && (!r_out_valid || out_ready);
    assign w_p2_hold = r_vld_pipe[2] && r_p2_last && !w_load;
    assign w_p3_fire = r_vld_pipe[2] && !w_p2_hold;

    assign out_valid = r_out_valid;
    assign acc_out   = r_acc_out;
    assign ovf_out   = r_ovf_out;
    assign cfg_err   = r_cfg_err;

    // P1 multipliers, one per lane
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        mac_acc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .PROD_WIDTH (PW)
        ) u_lane (
            .i_sgn  (w_sgn),
            .i_d    (data[i*DATA_WIDTH +: DATA_WIDTH]),
            .i_w    (weight[i*DATA_WIDTH +: DATA_WIDTH]),
            .o_prod (w_prod[i])
        );
    end

    // group lane windows from the captured config; total of active lanes for cfg_err
    always_comb begin
        w_run   = '0;
        w_tot   = '0;
        w_start = '0;
        w_end   = '0;
        w_act   = '0;
        for (int g = 0; g < MAX_GROUPS; g++) begin
            w_act[g]   = (GB'(g) < r_cfg_ng) && (r_cfg_gl[g] != '0);
            w_start[g] = w_run;
            w_end[g]   = w_run + SW'(r_cfg_gl[g]);
            w_run      = w_end[g];
            if (GB'(g) < r_cfg_ng)
                w_tot = w_tot + SW'(r_cfg_gl[g]);
        end
    end

    // P2 group sums: lanes past NUM_LANES simply do not exist and add nothing
    always_comb begin
        w_gsum = '0;
        for (int g = 0; g < MAX_GROUPS; g++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (w_act[g] && (SW'(i) >= w_start[g]) && (SW'(i) < w_end[g]))
                    w_gsum[g] = w_gsum[g] + GW'($signed(r_p1_prod[i]));
            end
        end
    end

    // P3 accumulate with wrap; overflow is carry-out (unsigned) or 2's-complement (signed)
    always_comb begin
        w_base    = '0;
        w_ext     = '0;
        w_sum     = '0;
        w_sov     = 1'b0;
        w_acc_nxt = '0;
        w_ovf_nxt = '0;
        for (int g = 0; g < MAX_GROUPS; g++) begin
            w_base       = r_p2_first ? '0 : r_acc[g];
            w_ext        = ACC_WIDTH'($signed(r_p2_sum[g]));
            w_sum        = {1'b0, w_base} + {1'b0, w_ext};
            w_sov        = (w_base[ACC_WIDTH-1] == w_ext[ACC_WIDTH-1]) &&
                           (w_sum[ACC_WIDTH-1] != w_base[ACC_WIDTH-1]);
            w_acc_nxt[g] = w_sum[ACC_WIDTH-1:0];
            w_ovf_nxt[g] = (!r_p2_first && r_ovf[g]) ||
                           (r_cfg_sgn ? w_sov : w_sum[ACC_WIDTH]);
        end
    end

    // handshake, config capture and stage valids
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_first        <= 1'b1;
            r_pending_last <= 1'b0;
            r_out_valid    <= 1'b0;
            r_vld_pipe     <= '0;
            r_cfg_ng       <= '0;
            r_cfg_gl       <= '0;
            r_cfg_sgn      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_first <= in_last;
                if (r_first) begin
                    r_cfg_ng  <= num_groups;
                    r_cfg_gl  <= group_lanes;
                    r_cfg_sgn <= is_signed;
                end
            end
            if (w_accept && in_last)
                r_pending_last <= 1'b1;
            else if (w_load)
                r_pending_last <= 1'b0;
            // P1 is always empty behind a held last beat, so it never needs to stall
            r_vld_pipe[1] <= w_accept;
            if (!w_p2_hold)
                r_vld_pipe[2] <= r_vld_pipe[1];
            if (w_load)
                r_out_valid <= 1'b1;
            else if (out_ready)
                r_out_valid <= 1'b0;
        end
    end

    // datapath registers: products, group sums, accumulators, output result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_p1_prod  <= '0;
            r_p1_first <= 1'b0;
            r_p1_last  <= 1'b0;
            r_p2_sum   <= '0;
            r_p2_first <= 1'b0;
            r_p2_last  <= 1'b0;
            r_acc      <= '0;
            r_ovf      <= '0;
            r_acc_out  <= '0;
            r_ovf_out  <= '0;
            r_cfg_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_p1_prod  <= w_prod;
                r_p1_first <= r_first;
                r_p1_last  <= in_last;
            end
            if (!w_p2_hold && r_vld_pipe[1]) begin
                r_p2_sum   <= w_gsum;
                r_p2_first <= r_p1_first;
                r_p2_last  <= r_p1_last;
            end
            if (w_p3_fire) begin
                r_acc <= w_acc_nxt;
                r_ovf <= w_ovf_nxt;
            end
            if (w_load) begin
                r_acc_out <= w_acc_nxt;
                r_ovf_out <= w_ovf_nxt;
                r_cfg_err <= (w_tot > SW'(NUM_LANES));
            end
        end
    end
endmodule

// File: tb/tb_mac_acc.sv
// tb_mac_acc: directed vectors for mac_acc. Two instances share every input;
// the second uses a 24-bit accumulator to exercise wrap-around.

module tb_mac_acc;
    localparam int NL = 64;
    localparam int DW = 8;
    localparam int MG = 8;
    localparam int LB = 7;
    localparam int GB = 4;

    localparam int T2_EXP [4] = '{360, 1128, 1896, 2664};

    logic            clk = 1'b0;
    logic            rst;
    logic [GB-1:0]   num_groups;
    logic [MG*LB-1:0] group_lanes;
    logic            is_signed;
    logic            in_valid, in_last, out_ready;
    logic [NL*DW-1:0] data, weight;

    logic            in_ready, out_valid, cfg_err;
    logic [MG*32-1:0] acc_out;
    logic [MG-1:0]   ovf_out;
    logic            in_ready24, out_valid24, cfg_err24;
    logic [MG*24-1:0] acc24;
    logic [MG-1:0]   ovf24;

    int n_vec = 0;
    int n_err = 0;
    int cyc;

    always #5 clk = ~clk;

    mac_acc #(.NUM_LANES(NL), .DATA_WIDTH(DW), .MAX_GROUPS(MG), .ACC_WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .num_groups(num_groups), .group_lanes(group_lanes),
        .is_signed(is_signed), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .data(data), .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
        .acc_out(acc_out), .ovf_out(ovf_out), .cfg_err(cfg_err)
    );

    mac_acc #(.NUM_LANES(NL), .DATA_WIDTH(DW), .MAX_GROUPS(MG), .ACC_WIDTH(24)) u_dut24 (
        .clk(clk), .rst(rst), .num_groups(num_groups), .group_lanes(group_lanes),
        .is_signed(is_signed), .in_valid(in_valid), .in_ready(in_ready24), .in_last(in_last),
        .data(data), .weight(weight), .out_valid(out_valid24), .out_ready(out_ready),
        .acc_out(acc24), .ovf_out(ovf24), .cfg_err(cfg_err24)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] acc32(input int g);
        return acc_out[g*32 +: 32];
    endfunction

    // every lane gets the same operand pair
    task automatic set_ops(input logic [7:0] d, input logic [7:0] w);
        for (int i = 0; i < NL; i++) begin
            data[i*DW +: DW]   = d;
            weight[i*DW +: DW] = w;
        end
    endtask

    // group 0 gets l0 lanes, group 1 gets l1, the rest 0
    task automatic set_cfg(input int ng, input int l0, input int l1, input logic sgn);
        num_groups  = GB'(ng);
        group_lanes = '0;
        group_lanes[0 +: LB]  = LB'(l0);
        group_lanes[LB +: LB] = LB'(l1);
        is_signed   = sgn;
    endtask

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic beat(input logic last);
        int n = 0;
        in_valid = 1'b1;
        in_last  = last;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("beat_ready_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_valid(output int c);
        c = 0;
        while (!out_valid && c < 20) begin
            @(negedge clk);
            c++;
        end
        if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
        num_groups = '0; group_lanes = '0; is_signed = 1'b0; data = '0; weight = '0;
        repeat (2) @(negedge clk);

        // reset state
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_acc0",      acc32(0),       32'd0);
        chk("rst_ovf",       32'(ovf_out),   32'd0);
        chk("rst_cfg_err",   32'(cfg_err),   32'd0);
        rst = 1'b1;
        @(negedge clk);

        // single beat, signed, 64 lanes of 2 * -3
        set_cfg(1, 64, 0, 1'b1);
        set_ops(8'd2, 8'hFD);
        beat(1'b1);
        wait_valid(cyc);
        chk("t1_latency", 32'(cyc),            32'd2);
        chk("t1_acc0",    acc32(0),            32'hFFFF_FE80);
        chk("t1_acc0_24", 32'(acc24[0 +: 24]), 32'h00FF_FE80);
        chk("t1_v24",     32'(out_valid24),    32'd1);
        chk("t1_acc1",    acc32(1),            32'd0);
        chk("t1_ovf",     32'(ovf_out),        32'd0);
        chk("t1_cfg_err", 32'(cfg_err),        32'd0);
        consume();
        chk("t1_drained", 32'(out_valid),      32'd0);
        chk("t1_hold",    acc32(0),            32'hFFFF_FE80);

        // 4 groups x 16 lanes, 3 beats, data=lane index, weight=1; groups 4..7 ignored
        num_groups = 4'd4;
        for (int g = 0; g < MG; g++) group_lanes[g*LB +: LB] = (g < 4) ? LB'(16) : LB'(5);
        is_signed = 1'b0;
        for (int i = 0; i < NL; i++) begin
            data[i*DW +: DW]   = DW'(i);
            weight[i*DW +: DW] = 8'd1;
        end
        beat(1'b0);
        beat(1'b0);
        chk("t2_not_early", 32'(out_valid), 32'd0);
        beat(1'b1);
        wait_valid(cyc);
        for (int g = 0; g < MG; g++)
            chk($sformatf("t2_acc%0d", g), acc32(g), (g < 4) ? 32'(T2_EXP[g]) : 32'd0);
        chk("t2_cfg_err", 32'(cfg_err), 32'd0);
        consume();

        // unsigned 255*255, 64 lanes, 9 beats: 37454400 fits 32b, wraps 24b
        set_cfg(1, 64, 0, 1'b0);
        set_ops(8'd255, 8'd255);
        repeat (8) beat(1'b0);
        beat(1'b1);
        wait_valid(cyc);
        chk("t3_acc32",   acc32(0),            32'd37454400);
        chk("t3_ovf32",   32'(ovf_out[0]),     32'd0);
        chk("t3_acc24",   32'(acc24[0 +: 24]), 32'd3899968);
        chk("t3_ovf24",   32'(ovf24[0]),       32'd1);
        chk("t3_cfg24",   32'(cfg_err24),      32'd0);
        consume();

        // group_lanes {40,40}: group 1 truncated to lanes 40..63
        set_cfg(2, 40, 40, 1'b1);
        set_ops(8'd1, 8'd1);
        beat(1'b1);
        wait_valid(cyc);
        chk("t4_acc0",    acc32(0),          32'd40);
        chk("t4_acc1",    acc32(1),          32'd24);
        chk("t4_cfg_err", 32'(cfg_err),      32'd1);
        chk("t4_ovf",     32'(ovf_out),      32'd0);
        consume();

        // backpressure: result A held while accumulation B completes behind it
        set_cfg(1, 64, 0, 1'b1);
        set_ops(8'd2, 8'hFD);
        beat(1'b1);
        wait_valid(cyc);
        set_ops(8'd1, 8'd1);
        beat(1'b0);
        beat(1'b1);
        chk("t5_ready_low",  32'(in_ready),  32'd0);
        repeat (6) @(negedge clk);
        chk("t5_held_valid", 32'(out_valid), 32'd1);
        chk("t5_held_acc",   acc32(0),       32'hFFFF_FE80);
        chk("t5_still_low",  32'(in_ready),  32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("t5_swap_valid", 32'(out_valid), 32'd1);
        chk("t5_swap_acc",   acc32(0),       32'd128);
        chk("t5_ready_back", 32'(in_ready),  32'd1);
        @(negedge clk);
        out_ready = 1'b0;
        chk("t5_drained",    32'(out_valid), 32'd0);
        chk("t5_acc_holds",  acc32(0),       32'd128);

        // reset during beat 2 of 4, then a clean single beat
        set_ops(8'd5, 8'd5);
        beat(1'b0);
        beat(1'b0);
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_valid",  32'(out_valid), 32'd0);
        chk("t6_rst_acc",    acc32(0),       32'd0);
        chk("t6_rst_ready",  32'(in_ready),  32'd1);
        chk("t6_rst_ready24",32'(in_ready24),32'd1);
        @(negedge clk);
        rst = 1'b1;
        set_ops(8'd1, 8'd1);
        beat(1'b1);
        wait_valid(cyc);
        chk("t6_clean_acc",  acc32(0),       32'd64);
        chk("t6_clean_ovf",  32'(ovf_out),   32'd0);
        consume();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
